bp_cfg_seq_loader: RTL

- Parametrised configuration-bus sequencer; successor to the static per-configuration parameter tables.
- After reset (or on start_i), walks a register-write table and issues each write to every core tile over a valid/ready config channel, with a bounded number of unacknowledged writes in flight.
- Holds all cores frozen until every write is acknowledged, then releases them together.
- Sits between the top-level bootstrap logic and the per-tile config-bus endpoints.

---
 rtl/bp_common_cfg_seq_pkg.sv | 29 ++
 rtl/bp_cfg_seq_credit_counter.sv | 53 +++++
 rtl/bp_cfg_seq_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bp_common_cfg_seq_pkg.sv
// Shared definitions for the configuration-bus sequencer and its helpers.
//   - BSG_SAFE_CLOG2 : clog2 that returns 1 for an argument of 1, so that
//                      single-element counters still get a real bit.
//   - BP_CFG_ENTRY_S : macro that declares the packed table entry type
//                      bp_cfg_entry_s {per_core, addr, data} for given field widths.
//   - bp_cfg_seq_state_e : sequencer FSM states.
//   - bp_cfg_broadcast_core_id_gp : broadcast core id (all ones). Slice it
//                      down to the core id width in use.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BP_CFG_ENTRY_S
`define BP_CFG_ENTRY_S(addr_width_mp, data_width_mp) typedef struct packed { logic per_core; logic [addr_width_mp-1:0] addr; logic [data_width_mp-1:0] data; } bp_cfg_entry_s
`endif

package bp_common_cfg_seq_pkg;

    typedef enum logic [2:0] {
        e_reset,
        e_send,
        e_drain,
        e_release,
        e_done
    } bp_cfg_seq_state_e;

    localparam logic [31:0] bp_cfg_broadcast_core_id_gp = '1;

endpackage

// File: rtl/bp_cfg_seq_credit_counter.sv
// Up/down counter of unacknowledged config writes.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   inc_i          : a write was accepted this cycle
//   dec_i          : an acknowledge arrived this cycle
//   count_o        : writes currently outstanding
//   full_o         : count_o has reached max_p, no more writes may be issued
//   underflow_o    : an acknowledge arrived while nothing was outstanding
module bp_cfg_seq_credit_counter
#(
    parameter int max_p = 4,
    localparam int width_lp = `BSG_SAFE_CLOG2(max_p+1)
)
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [width_lp-1:0] count_o,
    output logic                full_o,
    output logic                underflow_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_p);

    logic [width_lp-1:0] count_q, count_d;
    logic                zero;

    assign zero        = (count_q == '0);
    assign full_o      = (count_q == max_lp);
    assign count_o     = count_q;
    // A stray acknowledge is reported but never allowed to wrap the count.
    assign underflow_o = dec_i & zero;

    // Simultaneous inc and dec cancel; inc at full and dec at zero are dropped.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && !full_o) begin
            count_d = count_q + width_lp'(1);
        end else if (dec_i && !inc_i && !zero) begin
            count_d = count_q - width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bp_cfg_seq_loader.sv
// Configuration-bus sequencer. Walks a register-write table after reset (or
// on start_i once a pass has finished) and writes every entry to every core
// tile over a valid/ready channel, keeping at most max_outstanding_p writes
// unacknowledged. Cores stay frozen until every write has been acknowledged.
// Ports:
//   clk_i, reset_i      : clock, synchronous active-high reset
//   start_i             : starts another pass; only honoured when done
//   table_i             : num_reg_p entries {per_core, addr, data}, entry 0 in LSBs
//   cfg_v_o/cfg_ready_i : write handshake
//   cfg_core_o/addr/data: write destination core (all ones = broadcast), fields
//   cfg_ack_v_i         : one acknowledge per accepted write
//   freeze_o            : per-core freeze
//   busy_o, done_o      : pass in progress / pass finished and cores released
//   error_o             : sticky, acknowledge seen with nothing outstanding
module bp_cfg_seq_loader
    import bp_common_cfg_seq_pkg::*;
#(
    parameter int num_core_p        = 4,
    parameter int num_reg_p         = 8,
    parameter int cfg_addr_width_p  = 16,
    parameter int cfg_data_width_p  = 64,
    parameter int max_outstanding_p = 4,
    parameter int broadcast_p       = 0,
    localparam int core_id_width_lp = `BSG_SAFE_CLOG2(num_core_p)+1,
    localparam int entry_width_lp   = 1+cfg_addr_width_p+cfg_data_width_p
)
(
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic [num_reg_p*entry_width_lp-1:0] table_i,
    output logic                                cfg_v_o,
    input  logic                                cfg_ready_i,
    output logic [core_id_width_lp-1:0]         cfg_core_o,
    output logic [cfg_addr_width_p-1:0]         cfg_addr_o,
    output logic [cfg_data_width_p-1:0]         cfg_data_o,
    input  logic                                cfg_ack_v_i,
    output logic [num_core_p-1:0]               freeze_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o
);

    localparam int core_idx_width_lp = `BSG_SAFE_CLOG2(num_core_p);
    localparam int reg_idx_width_lp  = `BSG_SAFE_CLOG2(num_reg_p);
    localparam int credit_width_lp   = `BSG_SAFE_CLOG2(max_outstanding_p+1);

    localparam logic [reg_idx_width_lp-1:0]  last_reg_lp  = reg_idx_width_lp'(num_reg_p-1);
    localparam logic [core_idx_width_lp-1:0] last_core_lp = core_idx_width_lp'(num_core_p-1);
    localparam logic [core_id_width_lp-1:0]  bcast_id_lp  =
        bp_cfg_broadcast_core_id_gp[core_id_width_lp-1:0];

    `BP_CFG_ENTRY_S(cfg_addr_width_p, cfg_data_width_p);

    bp_cfg_seq_state_e              state_q, state_d;
    logic [reg_idx_width_lp-1:0]    reg_idx_q, reg_idx_d;
    logic [core_idx_width_lp-1:0]   core_idx_q, core_idx_d;
    logic [num_core_p-1:0]          freeze_q, freeze_d;
    logic                           error_q, error_d;

    bp_cfg_entry_s                  entry_li;
    logic [core_id_width_lp-1:0]    core_id_li;
    logic                           cfg_hs, ack_li, last_write;
    logic [credit_width_lp-1:0]     credit_count;
    logic                           credit_full, credit_underflow;

    assign entry_li   = table_i[reg_idx_q*entry_width_lp +: entry_width_lp];
    assign core_id_li = core_id_width_lp'(core_idx_q);
    assign cfg_hs     = cfg_v_o & cfg_ready_i;
    // Acks from a pass aborted by reset_i are dropped until e_reset is left.
    assign ack_li     = cfg_ack_v_i & (state_q != e_reset);
    assign last_write = (reg_idx_q == last_reg_lp) &&
                        ((broadcast_p != 0) || (core_idx_q == last_core_lp));

    bp_cfg_seq_credit_counter #(
        .max_p (max_outstanding_p)
    ) credit_counter (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .inc_i       (cfg_hs),
        .dec_i       (ack_li),
        .count_o     (credit_count),
        .full_o      (credit_full),
        .underflow_o (credit_underflow)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_reset;
            reg_idx_q  <= '0;
            core_idx_q <= '0;
            freeze_q   <= '1;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            core_idx_q <= core_idx_d;
            freeze_q   <= freeze_d;
            error_q    <= error_d;
        end
    end

    // Register index is the inner loop and core index the outer one; in
    // broadcast mode the core index never moves.
    always_comb begin
        state_d    = state_q;
        reg_idx_d  = reg_idx_q;
        core_idx_d = core_idx_q;
        freeze_d   = freeze_q;
        error_d    = error_q | credit_underflow;
        case (state_q)
            e_reset: begin
                state_d = e_send;
            end
            e_send: begin
                if (cfg_hs) begin
                    if (last_write) begin
                        reg_idx_d  = '0;
                        core_idx_d = '0;
                        state_d    = e_drain;
                    end else if (reg_idx_q == last_reg_lp) begin
                        reg_idx_d  = '0;
                        core_idx_d = core_idx_q + core_idx_width_lp'(1);
                    end else begin
                        reg_idx_d  = reg_idx_q + reg_idx_width_lp'(1);
                    end
                end
            end
            e_drain: begin
                if (credit_count == '0) begin
                    state_d = e_release;
                end
            end
            e_release: begin
                freeze_d = '0;
                state_d  = e_done;
            end
            e_done: begin
                if (start_i) begin
                    freeze_d   = '1;
                    reg_idx_d  = '0;
                    core_idx_d = '0;
                    state_d    = e_send;
                end
            end
            default: begin
                state_d = e_reset;
            end
        endcase
    end

    // Fields depend only on registered indices, so they hold steady while
    // cfg_v_o waits for cfg_ready_i.
    always_comb begin
        cfg_v_o    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        cfg_core_o = (broadcast_p != 0) ? bcast_id_lp : core_id_li;
        cfg_addr_o = entry_li.addr;
        cfg_data_o = entry_li.data;
        if (entry_li.per_core && (broadcast_p == 0)) begin
            cfg_data_o[core_id_width_lp-1:0] = core_id_li;
        end
        case (state_q)
            e_send: begin
                cfg_v_o = ~credit_full;
                busy_o  = 1'b1;
            end
            e_drain, e_release: begin
                busy_o = 1'b1;
            end
            e_done: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign freeze_o = freeze_q;
    assign error_o  = error_q;

endmodule
